// File: rtl/sincos_pkg.sv
// Shared widths and the lookup payload used by the sin/cos LUT arbiter.
package sincos_pkg;

    localparam int unsigned PHASE_W = 8;
    localparam int unsigned MAG_W   = 9;

    // One LUT result: sign/magnitude for cos and sin.
    typedef struct packed {
        logic             cos_sign;
        logic [MAG_W-1:0] cos_mag;
        logic             sin_sign;
        logic [MAG_W-1:0] sin_mag;
    } sincos_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // First pass searches [ptr, NUM_REQ-1]; second pass wraps to [0, ptr-1].
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sincos_lut_256x10.sv
// 256-step sin/cos lookup built from a first-quadrant cosine table plus quadrant folding.
module sincos_lut_256x10
    import sincos_pkg::*;
(
    input  logic [PHASE_W-1:0] phase,
    output sincos_t            lut_o
);

    // round(511 * cos(k * pi / 128)) for k = 0..64; sin of k is cos of 64-k.
    function automatic logic [MAG_W-1:0] qcos(input logic [6:0] k);
        logic [MAG_W-1:0] m;
        m = '0;
        case (k)
            7'd0:  m = 9'd511; 7'd1:  m = 9'd511; 7'd2:  m = 9'd510; 7'd3:  m = 9'd510;
            7'd4:  m = 9'd509; 7'd5:  m = 9'd507; 7'd6:  m = 9'd505; 7'd7:  m = 9'd503;
            7'd8:  m = 9'd501; 7'd9:  m = 9'd499; 7'd10: m = 9'd496; 7'd11: m = 9'd492;
            7'd12: m = 9'd489; 7'd13: m = 9'd485; 7'd14: m = 9'd481; 7'd15: m = 9'd477;
            7'd16: m = 9'd472; 7'd17: m = 9'd467; 7'd18: m = 9'd462; 7'd19: m = 9'd456;
            7'd20: m = 9'd451; 7'd21: m = 9'd445; 7'd22: m = 9'd438; 7'd23: m = 9'd432;
            7'd24: m = 9'd425; 7'd25: m = 9'd418; 7'd26: m = 9'd410; 7'd27: m = 9'd403;
            7'd28: m = 9'd395; 7'd29: m = 9'd387; 7'd30: m = 9'd379; 7'd31: m = 9'd370;
            7'd32: m = 9'd361; 7'd33: m = 9'd352; 7'd34: m = 9'd343; 7'd35: m = 9'd334;
            7'd36: m = 9'd324; 7'd37: m = 9'd314; 7'd38: m = 9'd304; 7'd39: m = 9'd294;
            7'd40: m = 9'd284; 7'd41: m = 9'd273; 7'd42: m = 9'd263; 7'd43: m = 9'd252;
            7'd44: m = 9'd241; 7'd45: m = 9'd230; 7'd46: m = 9'd218; 7'd47: m = 9'd207;
            7'd48: m = 9'd196; 7'd49: m = 9'd184; 7'd50: m = 9'd172; 7'd51: m = 9'd160;
            7'd52: m = 9'd148; 7'd53: m = 9'd136; 7'd54: m = 9'd124; 7'd55: m = 9'd112;
            7'd56: m = 9'd100; 7'd57: m = 9'd87;  7'd58: m = 9'd75;  7'd59: m = 9'd63;
            7'd60: m = 9'd50;  7'd61: m = 9'd38;  7'd62: m = 9'd25;  7'd63: m = 9'd13;
            default: m = 9'd0;
        endcase
        return m;
    endfunction

    logic [6:0] idx_c;
    logic [6:0] cidx_c;

    // Odd quadrants swap the cos/sin magnitudes; signs come straight from the top phase bits.
    always_comb begin
        idx_c          = {1'b0, phase[5:0]};
        cidx_c         = 7'd64 - idx_c;
        lut_o          = '0;
        lut_o.cos_sign = phase[7] ^ phase[6];
        lut_o.sin_sign = phase[7];
        if (phase[6]) begin
            lut_o.cos_mag = qcos(cidx_c);
            lut_o.sin_mag = qcos(idx_c);
        end else begin
            lut_o.cos_mag = qcos(idx_c);
            lut_o.sin_mag = qcos(cidx_c);
        end
    end

endmodule

// File: rtl/sincos_lut_arbiter.sv
// Shares one sin/cos LUT among NUM_REQ requesters via round-robin and a 2-stage valid/ready pipe.
module sincos_lut_arbiter
    import sincos_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*PHASE_W-1:0] req_phase,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [MAG_W-1:0]           cos_mag,
    output logic [MAG_W-1:0]           sin_mag,
    output logic                       cos_sign,
    output logic                       sin_sign,
    output logic                       busy
);

    logic               s1_valid_q, s1_valid_d;
    logic [PHASE_W-1:0] s1_phase_q, s1_phase_d;
    logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;
    logic [ID_W-1:0]    s1_id_q,    s1_id_d;
    logic               s2_valid_q, s2_valid_d;
    sincos_t            s2_sc_q,    s2_sc_d;
    logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;
    logic [ID_W-1:0]    s2_id_q,    s2_id_d;
    logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;

    logic               adv1_c;
    logic               adv2_c;
    logic               any_req_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    grant_idx_c;
    logic [PHASE_W-1:0] sel_phase_c;
    logic [TAG_W-1:0]   sel_tag_c;
    sincos_t            lut_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant_c),
        .grant_idx (grant_idx_c)
    );

    sincos_lut_256x10 u_lut (
        .phase (s1_phase_q),
        .lut_o (lut_c)
    );

    // Pipeline advance conditions and the granted requester's payload mux.
    always_comb begin
        adv2_c      = ~s2_valid_q | rsp_ready;
        adv1_c      = ~s1_valid_q | adv2_c;
        any_req_c   = |req_valid;
        sel_phase_c = '0;
        sel_tag_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_phase_c = req_phase[i*PHASE_W +: PHASE_W];
                sel_tag_c   = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // Next-state for both stages and the round-robin pointer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_phase_d = s1_phase_q;
        s1_tag_d   = s1_tag_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_sc_d    = s2_sc_q;
        s2_tag_d   = s2_tag_q;
        s2_id_d    = s2_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (adv2_c) begin
            s2_valid_d = s1_valid_q;
            s2_sc_d    = lut_c;
            s2_tag_d   = s1_tag_q;
            s2_id_d    = s1_id_q;
        end
        if (adv1_c) begin
            s1_valid_d = any_req_c;
            s1_phase_d = sel_phase_c;
            s1_tag_d   = sel_tag_c;
            s1_id_d    = grant_idx_c;
            if (any_req_c) begin
                rr_ptr_d = (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
            end
        end
    end

    // State registers with synchronous reset; reset drops any in-flight lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_phase_q <= '0;
            s1_tag_q   <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_sc_q    <= '0;
            s2_tag_q   <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_phase_q <= s1_phase_d;
            s1_tag_q   <= s1_tag_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_sc_q    <= s2_sc_d;
            s2_tag_q   <= s2_tag_d;
            s2_id_q    <= s2_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Response port is driven straight from stage 2; ready is the grant gated by stage-1 advance.
    always_comb begin
        req_ready = grant_c & {NUM_REQ{adv1_c}};
        rsp_valid = s2_valid_q;
        rsp_id    = s2_id_q;
        rsp_tag   = s2_tag_q;
        cos_mag   = s2_sc_q.cos_mag;
        sin_mag   = s2_sc_q.sin_mag;
        cos_sign  = s2_sc_q.cos_sign;
        sin_sign  = s2_sc_q.sin_sign;
        busy      = s1_valid_q | s2_valid_q;
    end

endmodule

// File: tb/tb_sincos_lut_arbiter.sv
// Randomized bench for sincos_lut_arbiter with a queue-based transaction model and real-math LUT reference.
module tb_sincos_lut_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TAG_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_phase;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [TAG_W-1:0]       rsp_tag;
    logic [8:0]             cos_mag;
    logic [8:0]             sin_mag;
    logic                   cos_sign;
    logic                   sin_sign;
    logic                   busy;

    always #5 clk = ~clk;

    sincos_lut_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_phase (req_phase),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .cos_mag   (cos_mag),
        .sin_mag   (sin_mag),
        .cos_sign  (cos_sign),
        .sin_sign  (sin_sign),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int tag;
        int phase;
        int acc;
    } ent_t;

    ent_t               q[$];
    int                 m_ptr;
    int                 cyc;
    int                 n_chk;
    int                 n_bad;
    logic [NUM_REQ-1:0] acc_vec;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Magnitude of cos/sin at phase*2*pi/256, scaled to 511 and rounded.
    function automatic int exp_mag(input int ph, input bit want_sin);
        real a;
        real v;
        a = 2.0 * 3.141592653589793 * real'(ph) / 256.0;
        v = want_sin ? $sin(a) : $cos(a);
        if (v < 0.0) v = -v;
        return $rtoi(511.0 * v + 0.5);
    endfunction

    // Check one cycle against the model, then advance the model across the coming edge.
    task automatic step();
        int                 g;
        int                 j;
        bit                 can;
        bit                 exp_rv;
        logic [NUM_REQ-1:0] exp_rdy;
        ent_t               e;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (m_ptr + k) % NUM_REQ;
            if (g < 0 && req_valid[j]) g = j;
        end
        can     = (q.size() < 2) || rsp_ready;
        exp_rdy = '0;
        if (g >= 0 && can) exp_rdy[g] = 1'b1;
        exp_rv  = (q.size() > 0) && (cyc - q[0].acc >= 2);
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("busy", 32'(busy), 32'(q.size() != 0));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            e = q[0];
            check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
            check_eq("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            check_eq("cos_mag", 32'(cos_mag), 32'(exp_mag(e.phase, 1'b0)));
            check_eq("sin_mag", 32'(sin_mag), 32'(exp_mag(e.phase, 1'b1)));
            check_eq("cos_sign", 32'(cos_sign), 32'(e.phase >= 64 && e.phase < 192));
            check_eq("sin_sign", 32'(sin_sign), 32'(e.phase >= 128));
            if (rsp_ready) void'(q.pop_front());
        end
        acc_vec = exp_rdy;
        if (g >= 0 && can) begin
            e.id    = g;
            e.tag   = int'(req_tag[g*TAG_W +: TAG_W]);
            e.phase = int'(req_phase[g*8 +: 8]);
            e.acc   = cyc;
            q.push_back(e);
            m_ptr = (g + 1) % NUM_REQ;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input int ph, input int tg);
        req_valid[i]             = 1'b1;
        req_phase[i*8 +: 8]      = 8'(ph);
        req_tag[i*TAG_W +: TAG_W] = TAG_W'(tg);
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < NUM_REQ; i++) if (acc_vec[i]) req_valid[i] = 1'b0;
    endtask

    // Requesters in mask that were accepted or idle get fresh random requests.
    task automatic refresh(input int p_on, input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i] && (acc_vec[i] || !req_valid[i])) begin
                req_valid[i]              = ($urandom_range(99) < p_on);
                req_phase[i*8 +: 8]       = 8'($urandom);
                req_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom);
            end
        end
    endtask

    task automatic drain();
        repeat (10) begin
            step();
            drop_accepted();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check_eq("rst_mags", 32'({cos_mag, sin_mag}), 32'd0);
        check_eq("rst_signs", 32'({cos_sign, sin_sign}), 32'd0);
        rst = 1'b0;
        q.delete();
        m_ptr   = 0;
        acc_vec = '0;
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        cyc       = 0;
        m_ptr     = 0;
        acc_vec   = '0;
        rst       = 1'b1;
        req_valid = '0;
        req_phase = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Single lookups: phases 0x00, 0x40, 0xA0.
        put(0, 8'h00, 3);
        step();
        drop_accepted();
        repeat (3) step();
        put(1, 8'h40, 5);
        put(2, 8'hA0, 9);
        repeat (6) begin
            step();
            drop_accepted();
        end

        // All requesters streaming, then a 5-cycle response stall.
        refresh(100, '1);
        repeat (16) begin
            step();
            refresh(100, '1);
        end
        rsp_ready = 1'b0;
        repeat (5) begin
            step();
            refresh(100, '1);
        end
        rsp_ready = 1'b1;
        repeat (8) begin
            step();
            refresh(100, '1);
        end
        drain();

        // Only requesters 2 and 3 from pointer 0, then requester 0 joins.
        do_reset();
        put(2, 8'h10, 1);
        put(3, 8'h90, 2);
        repeat (4) begin
            step();
            refresh(100, 4'b1100);
        end
        put(0, 8'hC4, 7);
        repeat (6) begin
            step();
            refresh(100, 4'b1101);
        end
        drain();

        // Reset with both stages full.
        refresh(100, '1);
        rsp_ready = 1'b0;
        repeat (3) begin
            step();
            refresh(100, '1);
        end
        do_reset();
        rsp_ready = 1'b1;
        repeat (6) begin
            step();
            refresh(100, '1);
        end
        drain();

        // Random traffic and random back-pressure.
        repeat (3000) begin
            rsp_ready = ($urandom_range(3) != 0);
            step();
            refresh(50, '1);
        end
        rsp_ready = 1'b1;
        drain();
        check_eq("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
